// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the seq_mul_hs sequential multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_mul_state_e;

  // Index of the highest set bit; 0 for a zero value.
  function automatic int unsigned msb_index(input logic [31:0] value);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (value[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/seq_mul_step.sv
// One combinational shift-and-add step of the sequential multiplier.
module seq_mul_step
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] a_sh,
  input  logic [WIDTH-1:0]   b_sh,
  input  logic [CNT_W-1:0]   cnt,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] a_sh_next,
  output logic [WIDTH-1:0]   b_sh_next,
  output logic [CNT_W-1:0]   cnt_next,
  output logic               done
);

  always_comb begin
    acc_next  = acc + (b_sh[0] ? a_sh : '0);
    a_sh_next = a_sh << 1;
    b_sh_next = b_sh >> 1;
    cnt_next  = cnt + 1'b1;
    // Stop as soon as no multiplier bits remain; cnt bound is a safety net.
    done      = (b_sh_next == '0) || (a_sh == '0) || (cnt == CNT_W'(WIDTH - 1));
  end

endmodule

// File: rtl/seq_mul_hs.sv
// Shift-and-add WIDTH x WIDTH multiplier with valid/ready on both sides and early exit.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module seq_mul_hs
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] o,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  seq_mul_state_e     state_q, state_d;
  logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] o_q, o_d;

  logic [2*WIDTH-1:0] step_acc, step_a_sh;
  logic [WIDTH-1:0]   step_b_sh;
  logic [CNT_W-1:0]   step_cnt;
  logic               step_done;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] result;

`ifdef SEQ_MUL_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitudes are unsigned WIDTH bits, so the most negative operand maps cleanly.
  assign mag_a  = a[WIDTH-1] ? -a : a;
  assign mag_b  = b[WIDTH-1] ? -b : b;
  assign result = neg_q ? -step_acc : step_acc;
`else
  assign mag_a  = a;
  assign mag_b  = b;
  assign result = step_acc;
`endif

  seq_mul_step #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_step (
    .acc      (acc_q),
    .a_sh     (a_sh_q),
    .b_sh     (b_sh_q),
    .cnt      (cnt_q),
    .acc_next (step_acc),
    .a_sh_next(step_a_sh),
    .b_sh_next(step_b_sh),
    .cnt_next (step_cnt),
    .done     (step_done)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
`ifdef SEQ_MUL_SIGNED_EN
    neg_d   = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = {{WIDTH{1'b0}}, mag_a};
          b_sh_d  = mag_b;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SEQ_MUL_SIGNED_EN
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d  = step_acc;
        a_sh_d = step_a_sh;
        b_sh_d = step_b_sh;
        cnt_d  = step_cnt;
        if (step_done) begin
          o_d     = result;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign o         = o_q;

endmodule

// File: tb/tb_seq_mul_hs.sv
// Scoreboard bench for seq_mul_hs: directed operands, product and handshake-latency checks.
// Latency counts edges from the accept edge (inclusive) to the edge that raises out_valid.
module tb_seq_mul_hs;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] o;
  logic           busy;

  logic           m_in_valid = 1'b0;
  logic           m_in_ready;
  logic [W-1:0]   m_b = '0;
  logic           m_out_valid;
  logic [2*W-1:0] m_o;
  logic           m_busy;

  seq_mul_hs #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .o        (o),
    .busy     (busy)
  );

  // Second copy for the timing miter; shares a and always accepts its output.
  seq_mul_hs #(.WIDTH(W)) u_miter (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (m_in_valid),
    .in_ready (m_in_ready),
    .a        (a),
    .b        (m_b),
    .out_valid(m_out_valid),
    .out_ready(1'b1),
    .o        (m_o),
    .busy     (m_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2*W-1:0] o;
    int unsigned    lat;
    int unsigned    acc_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops an expectation on every output handshake; checks hold while stalled.
  initial begin
    logic           prev_ov = 1'b0;
    logic           prev_hs = 1'b0;
    logic [2*W-1:0] prev_o = '0;
    int unsigned    rise_cyc = 0;
    exp_t           e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_ov && !prev_hs) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_o", 32'(o), 32'(prev_o));
        end
        if (out_valid && !prev_ov) rise_cyc = cyc;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got o=%0h with no pending operation", o);
          end else begin
            e = sb.pop_front();
            check("product", 32'(o), 32'(e.o));
            check("latency", rise_cyc - e.acc_cyc + 1, e.lat);
          end
        end
        prev_ov = out_valid;
        prev_hs = out_valid && out_ready;
        prev_o  = o;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [2*W-1:0] eo, input int unsigned lat, input bit track);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      fail_now("issue_wait");
      return;
    end
    in_valid = 1'b1;
    a = ia;
    b = ib;
    e.o = eo;
    e.lat = lat;
    e.acc_cyc = cyc + 1;
    if (track) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic miter(input logic [W-1:0] ia, input logic [W-1:0] ib1, input logic [W-1:0] ib2,
                       input logic [2*W-1:0] eo1, input logic [2*W-1:0] eo2,
                       input int unsigned lat1, input bit same);
    exp_t        e;
    int unsigned r1 = 0;
    int unsigned r2 = 0;
    int          n = 0;
    drain();
    in_valid   = 1'b1;
    m_in_valid = 1'b1;
    a   = ia;
    b   = ib1;
    m_b = ib2;
    e.o = eo1;
    e.lat = lat1;
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    m_in_valid = 1'b0;
    while ((r1 == 0 || r2 == 0) && n < 40) begin
      @(negedge clk);
      if (out_valid && r1 == 0) r1 = cyc;
      if (m_out_valid && r2 == 0) begin
        r2 = cyc;
        check("miter_o", 32'(m_o), 32'(eo2));
      end
      n++;
    end
    @(posedge clk); #1;
    if (r1 == 0 || r2 == 0) fail_now("miter_wait");
    else check("miter_same_timing", 32'(r1 == r2), 32'(same));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_o", 32'(o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back directed vectors with out_ready held high.
`ifdef SEQ_MUL_SIGNED_EN
    issue(8'hFD, 8'h05, 16'hFFF1, 4, 1'b1);
    issue(8'h80, 8'h80, 16'h4000, 9, 1'b1);
    issue(8'h05, 8'hFE, 16'hFFF6, 3, 1'b1);
    issue(8'h00, 8'hFB, 16'h0000, 2, 1'b1);
    issue(8'hFF, 8'hFF, 16'h0001, 2, 1'b1);
    issue(8'h7F, 8'h81, 16'hC0FF, 8, 1'b1);
`else
    issue(8'd255, 8'd255, 16'hFE01, 9, 1'b1);
    issue(8'd13, 8'd0, 16'h0000, 2, 1'b1);
    issue(8'd0, 8'd200, 16'h0000, 2, 1'b1);
    issue(8'd100, 8'd100, 16'h2710, 8, 1'b1);
    issue(8'd1, 8'd128, 16'h0080, 9, 1'b1);
    issue(8'd37, 8'd1, 16'h0025, 2, 1'b1);
    issue(8'd12, 8'd10, 16'h0078, 5, 1'b1);
`endif
    drain();

    // Stalled output; in_valid pulses during BUSY and DONE must be ignored.
    out_ready = 1'b0;
    issue(8'd6, 8'd5, 16'd30, 4, 1'b1);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a = 8'd9;
      b = 8'd9;
      check("busy_in_ready", 32'(in_ready), 32'd0);
      check("busy_flag", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_rise", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("done_o", 32'(o), 32'd30);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("no_capture_busy", 32'(busy), 32'd0);
    check("no_capture_ready", 32'(in_ready), 32'd1);

    // Reset during the third BUSY cycle discards the product.
    issue(8'd100, 8'd100, 16'h2710, 8, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_o", 32'(o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("post_rst_idle", 32'(out_valid), 32'd0);

    // Timing miter: equal msb_index -> equal timing; different -> differs.
    miter(8'd77, 8'd9, 8'd15, 16'd693, 16'd1155, 5, 1'b1);
    miter(8'd77, 8'd9, 8'd40, 16'd693, 16'd3080, 5, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mul_hs.md
Name: seq_mul_hs

Overview:
- Parametrised shift-and-add sequential multiplier: WIDTH x WIDTH -> 2*WIDTH product.
- Full valid/ready handshake on both input and output sides.
- Early termination when the remaining multiplier bits are zero, or when a is zero.
- Drop-in arithmetic unit for datapaths and for the team's equivalence/miter harnesses. Latency is data-dependent, so it is a useful timing-leak target.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, step counter width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  product o valid.
- out_ready  input  1  consumer accepts product.
- o  output  2*WIDTH  product; held stable while out_valid && !out_ready.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset is asynchronous and active-low: clk is the single clock, rst_n clears all state immediately.
  - After reset: state=IDLE, in_ready=1, out_valid=0, busy=0, o=0.
  - Internal a_sh, b_sh, acc and cnt are all 0.
  - Reset mid-operation discards the product; no out_valid is produced.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid: load a_sh={WIDTH'0,a}, b_sh=b, acc=0, cnt=0; go to BUSY.
  - BUSY:
    - Each cycle: acc += b_sh[0] ? a_sh : 0; a_sh <<= 1; b_sh >>= 1; cnt++.
    - If the new b_sh==0, or a_sh==0, or cnt==WIDTH-1: go to DONE.
  - DONE:
    - out_valid=1, o=acc.
    - On out_ready: go to IDLE, clear acc.
- BUSY lasts max(1, msb_index(b)+1) cycles, where b=0 counts as 1 cycle.
  - a==0 also gives exactly 1 BUSY cycle.
- Latency: out_valid rises (BUSY cycles + 1) edges after the accept edge. Worst case is WIDTH+1 edges.
- Arithmetic:
  - acc is 2*WIDTH bits. Additions never overflow, because the product of two WIDTH-bit numbers fits in 2*WIDTH bits.
  - o is fully registered; there is no combinational path from inputs to outputs.
- Handshake:
  - in_valid while not IDLE is ignored; operands are not captured and not queued.
  - in_ready does not depend on in_valid.
  - out_valid, once high, stays high with o unchanged until out_ready.
  - out_ready while out_valid=0 has no effect.
  - The earliest new accept is the edge after the out_ready handshake. There is no same-cycle output-accept/input-accept overlap.

Optional Feature:
- Macro: SEQ_MUL_SIGNED_EN.
- When defined:
  - Operands are two's complement.
  - On accept: capture neg=a[W-1]^b[W-1], load a_sh=|a|, b_sh=|b|. Magnitudes are unsigned WIDTH bits, so -2^(W-1) is legal.
  - On entering DONE: o=neg ? -acc : acc, in 2*WIDTH-bit two's complement.
  - A zero product is never negated to a nonzero value.
  - Latency is determined by |b|.
- When undefined:
  - Operands are unsigned; neg logic is absent.
  - Behaviour is exactly as above.

Decomposition:
- Package seq_mul_pkg:
  - state enum seq_mul_state_e {IDLE, BUSY, DONE}, 2 bits.
  - Function msb_index(value) for the bench latency model.
- One sub-module, seq_mul_step: combinational single step.
  - Inputs: acc, a_sh, b_sh, cnt.
  - Outputs: next values and the done flag.
  - seq_mul_hs holds the FSM, the registers, and the sign logic.

Test Plan:
- WIDTH=8, unsigned, a=255, b=255, out_ready=1 -> 8 BUSY cycles; out_valid 9 edges after accept; o=16'hFE01.
- a=13, b=0 -> 1 BUSY cycle, o=0. Then a=0, b=200 -> 1 BUSY cycle, o=0.
- a=6, b=5, out_ready held low 4 cycles -> o=30 stable and out_valid high throughout; in_valid pulsed during BUSY/DONE is ignored (in_ready=0).
- SEQ_MUL_SIGNED_EN, a=8'hFD (-3), b=5 -> 3 BUSY cycles, o=16'hFFF1 (-15). Also a=-128, b=-128 -> o=16'h4000.
- Accept a=100, b=100, assert rst_n=0 during BUSY cycle 3 -> out_valid/busy drop immediately, in_ready=1, o=0, no stray out_valid.
- Miter: two instances, same a, different nonzero b of equal msb_index -> out_valid cycles identical; different msb_index -> out_valid timing differs (expected counterexample).
